// File: rtl/fpga_input_debounce_if.sv
// Pin-group bundle: raw pins in, debounced level and press/release pulses out.
// master drives the raw pins; slave is the debouncer.
interface fpga_input_debounce_if #(
    parameter int N_IN = 4
);
    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] level;
    logic [N_IN-1:0] pressed;
    logic [N_IN-1:0] press;
    logic [N_IN-1:0] release_pulse;

    modport master (
        output raw_in,
        input  level,
        input  pressed,
        input  press,
        input  release_pulse
    );

    modport slave (
        input  raw_in,
        output level,
        output pressed,
        output press,
        output release_pulse
    );
endinterface

// File: rtl/fpga_input_debounce.sv
// Per-bit two-flop sync, debounce and edge detect for raw KEY/SW pins.
// Latency 1+DEBOUNCE_CYCLES edges after s1 capture; no backpressure, all outputs are flops.
module fpga_input_debounce #(
    parameter int              N_IN            = 4,
    parameter int              DEBOUNCE_CYCLES = 1000000,
    parameter logic [N_IN-1:0] IDLE_LEVEL      = {N_IN{1'b1}}
) (
    input logic                  CLK,
    input logic                  RST,
    fpga_input_debounce_if.slave io
);
    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N_IN-1:0] s1_q;
    logic [N_IN-1:0] s2_q;
    logic [N_IN-1:0] level_q;
    logic [N_IN-1:0] level_d;
    logic [N_IN-1:0] pressed_q;
    logic [N_IN-1:0] pressed_d;
    logic [N_IN-1:0] press_q;
    logic [N_IN-1:0] press_d;
    logic [N_IN-1:0] release_q;
    logic [N_IN-1:0] release_d;
    logic [CW-1:0]   cnt_q [N_IN];
    logic [CW-1:0]   cnt_d [N_IN];

    // Any sample matching the accepted level restarts the count from zero.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s2_q[i];
                cnt_d[i]   = '0;
                if (s2_q[i] != IDLE_LEVEL[i]) begin
                    press_d[i] = 1'b1;
                end else begin
                    release_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        pressed_d = level_d ^ IDLE_LEVEL;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= IDLE_LEVEL;
            s2_q      <= IDLE_LEVEL;
            level_q   <= IDLE_LEVEL;
            pressed_q <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= io.raw_in;
            s2_q      <= s1_q;
            level_q   <= level_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io.level         = level_q;
    assign io.pressed       = pressed_q;
    assign io.press         = press_q;
    assign io.release_pulse = release_q;
endmodule

// File: tb/tb_fpga_input_debounce.sv
// Scoreboard bench: each stimulus change pushes its predicted pulse; a negedge monitor pops and checks.
module tb_fpga_input_debounce;
    localparam int N   = 4;
    localparam int DC  = 4;
    localparam int LAT = DC + 2;   // negedge drive at cycle c -> pulse visible at negedge of cycle c+LAT

    typedef struct {
        int cyc;
        int ch;
        bit is_press;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    ev_t  sb[$];

    fpga_input_debounce_if #(.N_IN(N)) io ();

    fpga_input_debounce #(
        .N_IN           (N),
        .DEBOUNCE_CYCLES(DC),
        .IDLE_LEVEL     (4'b1111)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .io (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int c, input int ch, input bit p);
        ev_t e;
        e.cyc      = c;
        e.ch       = ch;
        e.is_press = p;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the scoreboard head; overdue entries are misses.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missed_pulse_cyc", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        for (int ch = 0; ch < N; ch++) begin
            if (io.press[ch] === 1'b1 || io.release_pulse[ch] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse_ch", ch, -1);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("pulse_cyc", cyc, e.cyc);
                    chk("pulse_ch", ch, e.ch);
                    chk("pulse_is_press", int'(io.press[ch]), int'(e.is_press));
                    chk("pulse_excl", int'(io.press[ch] & io.release_pulse[ch]), 0);
                    chk("pulse_level", int'(io.level[ch]), e.is_press ? 0 : 1);
                    chk("pulse_pressed", int'(io.pressed[ch]), int'(e.is_press));
                end
            end
        end
    end

    initial begin
        io.raw_in = 4'b0000;

        // Reset with pins low: outputs held at idle.
        step(3);
        chk("rst_level", int'(io.level), 4'b1111);
        chk("rst_pressed", int'(io.pressed), 0);
        chk("rst_press", int'(io.press), 0);
        chk("rst_release", int'(io.release_pulse), 0);
        rst = 1'b0;
        for (int ch = 0; ch < N; ch++) expect_pulse(cyc + LAT, ch, 1'b1);
        step(LAT - 1);
        chk("post_rst_level_before", int'(io.level), 4'b1111);
        step(4);
        chk("post_rst_level", int'(io.level), 4'b0000);
        chk("post_rst_pressed", int'(io.pressed), 4'b1111);
        io.raw_in = 4'b1111;
        for (int ch = 0; ch < N; ch++) expect_pulse(cyc + LAT, ch, 1'b0);
        step(10);

        // Clean press and release on bit 0.
        io.raw_in[0] = 1'b0;
        expect_pulse(cyc + LAT, 0, 1'b1);
        step(10);
        chk("clean_level0", int'(io.level[0]), 0);
        io.raw_in[0] = 1'b1;
        expect_pulse(cyc + LAT, 0, 1'b0);
        step(10);

        // Bounce on bit 1: 2-cycle excursions never accepted.
        for (int i = 0; i < 10; i++) begin
            io.raw_in[1] = ~io.raw_in[1];
            step(2);
        end
        chk("bounce_level1", int'(io.level[1]), 1);
        io.raw_in[1] = 1'b0;
        expect_pulse(cyc + LAT, 1, 1'b1);
        step(10);
        io.raw_in[1] = 1'b1;
        expect_pulse(cyc + LAT, 1, 1'b0);
        step(10);

        // Threshold on bit 2: 3 samples rejected, 4 accepted.
        io.raw_in[2] = 1'b0;
        step(3);
        io.raw_in[2] = 1'b1;
        step(8);
        chk("thr3_level2", int'(io.level[2]), 1);
        io.raw_in[2] = 1'b0;
        expect_pulse(cyc + LAT, 2, 1'b1);
        step(4);
        io.raw_in[2] = 1'b1;
        expect_pulse(cyc + LAT, 2, 1'b0);
        step(10);

        // Parallel change on bits 0 and 3.
        io.raw_in = 4'b0110;
        expect_pulse(cyc + LAT, 0, 1'b1);
        expect_pulse(cyc + LAT, 3, 1'b1);
        step(10);
        chk("par_level", int'(io.level), 4'b0110);
        io.raw_in = 4'b1111;
        expect_pulse(cyc + LAT, 0, 1'b0);
        expect_pulse(cyc + LAT, 3, 1'b0);
        step(10);

        // Repeat, reset at count 2: partial count discarded, restart after reset.
        io.raw_in = 4'b0110;
        step(4);
        rst = 1'b1;
        step(1);
        chk("midrst_level", int'(io.level), 4'b1111);
        chk("midrst_pressed", int'(io.pressed), 0);
        rst = 1'b0;
        expect_pulse(cyc + LAT, 0, 1'b1);
        expect_pulse(cyc + LAT, 3, 1'b1);
        step(LAT - 1);
        chk("midrst_restart_level", int'(io.level), 4'b1111);
        step(5);
        io.raw_in = 4'b1111;
        expect_pulse(cyc + LAT, 0, 1'b0);
        expect_pulse(cyc + LAT, 3, 1'b0);
        step(12);

        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
